// File: rtl/cfg_reg_block_if.sv
// Request/response bus between the APB4 bridge and cfg_reg_block.
// Handshake: bus_req is valid for exactly one cycle per access and bus_ready answers it in that same cycle, so there is no backpressure.
interface cfg_reg_block_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                    bus_req;
  logic                    bus_req_is_wr;
  logic [ADDR_WIDTH-1:0]   bus_addr;
  logic [DATA_WIDTH-1:0]   bus_wr_data;
  logic [DATA_WIDTH/8-1:0] bus_wr_biten;
  logic                    bus_ready;
  logic                    bus_err;
  logic [DATA_WIDTH-1:0]   bus_rd_data;

  modport master (
    output bus_req, bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten,
    input  bus_ready, bus_err, bus_rd_data
  );

  modport slave (
    input  bus_req, bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten,
    output bus_ready, bus_err, bus_rd_data
  );
endinterface

// File: rtl/cfg_reg_block.sv
// Peripheral register block: ID, CTRL, W1C STATUS, SCRATCH and a prescaled compare timer with level irq.
// The timer (COMPARE, COUNT, CTRL timer bits, STATUS[8]) is built only when CFG_REG_BLOCK_TIMER_EN is defined.
module cfg_reg_block #(
  parameter int          ADDR_WIDTH = 5,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] ID_VALUE   = 32'hC0DE_0001
) (
  input  logic                  clk,
  input  logic                  rst,
  cfg_reg_block_if.slave        bus,
  input  logic [7:0]            hw_event,
  output logic [31:0]           ctrl_scratch,
  output logic                  irq
);
  localparam int IW = ADDR_WIDTH - 2;
  localparam logic [IW-1:0] IDX_ID      = IW'(0);
  localparam logic [IW-1:0] IDX_CTRL    = IW'(1);
  localparam logic [IW-1:0] IDX_STATUS  = IW'(2);
  localparam logic [IW-1:0] IDX_SCRATCH = IW'(3);
  localparam logic [IW-1:0] IDX_COMPARE = IW'(4);
  localparam logic [IW-1:0] IDX_COUNT   = IW'(5);

`ifdef CFG_REG_BLOCK_TIMER_EN
  localparam logic        HAS_TIMER  = 1'b1;
  localparam logic [31:0] CTRL_WMASK = 32'h0000_FF03;
`else
  localparam logic        HAS_TIMER  = 1'b0;
  localparam logic [31:0] CTRL_WMASK = 32'h0000_0002;
`endif

  logic [IW-1:0]         word_idx;
  logic                  wr_en, rd_en;
  logic                  sel_id, sel_ctrl, sel_status, sel_scratch, sel_compare, sel_count;
  logic                  mapped;
  logic [DATA_WIDTH-1:0] wmask;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic [31:0]           ctrl_q, ctrl_d;
  logic [31:0]           scratch_q, scratch_d;
  logic [8:0]            status_q, status_d, status_clr;
  logic                  irq_q, irq_d;
  logic                  tmr_match;
  logic [31:0]           count_rd, compare_rd;
  logic                  unused_addr;

  assign word_idx    = bus.bus_addr[ADDR_WIDTH-1:2];
  assign unused_addr = ^bus.bus_addr[1:0];
  assign wr_en       = bus.bus_req &&  bus.bus_req_is_wr;
  assign rd_en       = bus.bus_req && !bus.bus_req_is_wr;

  assign sel_id      = (word_idx == IDX_ID);
  assign sel_ctrl    = (word_idx == IDX_CTRL);
  assign sel_status  = (word_idx == IDX_STATUS);
  assign sel_scratch = (word_idx == IDX_SCRATCH);
  assign sel_compare = (word_idx == IDX_COMPARE);
  assign sel_count   = (word_idx == IDX_COUNT);
  assign mapped      = sel_id | sel_ctrl | sel_status | sel_scratch |
                       (HAS_TIMER & (sel_compare | sel_count));

  assign bus.bus_ready = bus.bus_req;
  assign bus.bus_err   = bus.bus_req && (!mapped || (bus.bus_req_is_wr && sel_id));

  always_comb begin
    wmask = '0;
    for (int i = 0; i < DATA_WIDTH/8; i++) begin
      wmask[8*i +: 8] = {8{bus.bus_wr_biten[i]}};
    end
  end

  always_comb begin
    ctrl_d     = ctrl_q;
    scratch_d  = scratch_q;
    status_clr = '0;
    if (wr_en && sel_ctrl) begin
      ctrl_d = (ctrl_q & ~(wmask & CTRL_WMASK)) | (bus.bus_wr_data & wmask & CTRL_WMASK);
    end
    if (wr_en && sel_scratch) begin
      scratch_d = (scratch_q & ~wmask) | (bus.bus_wr_data & wmask);
    end
    if (wr_en && sel_status) begin
      status_clr = bus.bus_wr_data[8:0] & wmask[8:0];
    end
    // Set terms are OR-ed after the clear so a same-cycle event beats a W1C.
    status_d = (status_q & ~status_clr) | {tmr_match, hw_event};
    irq_d    = ctrl_q[1] && (|status_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q    <= '0;
      scratch_q <= '0;
      status_q  <= '0;
      irq_q     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      scratch_q <= scratch_d;
      status_q  <= status_d;
      irq_q     <= irq_d;
    end
  end

`ifdef CFG_REG_BLOCK_TIMER_EN
  logic [7:0]  presc_q, presc_d;
  logic [31:0] count_q, count_d, compare_q, compare_d;
  logic        tick;

  always_comb begin
    tick      = ctrl_q[0] && (presc_q == ctrl_q[15:8]);
    tmr_match = tick && (count_q == compare_q);
    presc_d   = (!ctrl_q[0] || tick) ? 8'd0 : presc_q + 8'd1;
    count_d   = count_q;
    compare_d = compare_q;
    if (tick) begin
      count_d = tmr_match ? 32'd0 : count_q + 32'd1;
    end
    // A bus load of COUNT overrides whatever the tick would have done.
    if (wr_en && sel_count) begin
      count_d = (count_q & ~wmask) | (bus.bus_wr_data & wmask);
    end
    if (wr_en && sel_compare) begin
      compare_d = (compare_q & ~wmask) | (bus.bus_wr_data & wmask);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      count_q   <= '0;
      compare_q <= '0;
    end else begin
      presc_q   <= presc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
    end
  end

  assign count_rd   = count_q;
  assign compare_rd = compare_q;
`else
  assign tmr_match  = 1'b0;
  assign count_rd   = '0;
  assign compare_rd = '0;
`endif

  always_comb begin
    rd_mux = '0;
    if (sel_id)           rd_mux = ID_VALUE;
    else if (sel_ctrl)    rd_mux = ctrl_q;
    else if (sel_status)  rd_mux = {23'd0, status_q};
    else if (sel_scratch) rd_mux = scratch_q;
    else if (sel_compare) rd_mux = compare_rd;
    else if (sel_count)   rd_mux = count_rd;
  end

  assign bus.bus_rd_data = (rd_en && !rst) ? rd_mux : '0;
  assign ctrl_scratch    = scratch_q;
  assign irq             = irq_q;
endmodule
